// File: rtl/multdiv_sequencer_if.sv
// Operation types shared with the decoder, and the request/response bundle
// between the execute stage (master) and the multiply/divide unit (slave).
package decode_pkg;
    typedef enum logic [2:0] {
        MULT_MUL  = 3'd0,
        MULT_MULW = 3'd1,
        MULT_DIV  = 3'd2,
        MULT_DIVU = 3'd3,
        MULT_REM  = 3'd4,
        MULT_REMU = 3'd5
    } mult_t;
endpackage

interface multdiv_sequencer_if #(parameter int XLEN = 64);
    import decode_pkg::*;

    logic            req_valid;
    logic            req_ready;
    mult_t           mult_type;
    logic            word;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            flush;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] result;

    modport master (
        output req_valid, mult_type, word, src_a, src_b, flush, resp_ready,
        input  req_ready, resp_valid, result
    );

    modport slave (
        input  req_valid, mult_type, word, src_a, src_b, flush, resp_ready,
        output req_ready, resp_valid, result
    );
endinterface

// File: rtl/multdiv_sequencer.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, one operation in flight at a time.
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// MUL   | shift-add iterations, counter N-1 down to 0
// DIV   | restoring-divide iterations, counter N-1 down to 0
// DONE  | result held with resp_valid until resp_ready
module multdiv_sequencer
    import decode_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic                 clk,
    input  logic                 resetn,
    multdiv_sequencer_if.slave   bus
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_FULL = CW'(XLEN - 1);
    localparam logic [CW-1:0] CNT_WORD = CW'(31);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            word_q, rem_q, q_neg, r_neg;
    logic [XLEN-1:0] acc, mcand, mplier;
    logic [XLEN-1:0] rem, quo, divisor;
    logic            req_ready_q, resp_valid_q;
    logic [XLEN-1:0] result_q;

    logic            word_in, mul_in, signed_in, rem_in, sa, sb, div_zero, ovf;
    logic [XLEN-1:0] a_ext, b_ext, min_ext, mag_a, mag_b, spec_raw, spec_res;

    // Request decode: operand extension, sign capture and IDLE->DONE shortcuts.
    always_comb begin
        word_in   = bus.word | (bus.mult_type == MULT_MULW);
        mul_in    = (bus.mult_type == MULT_MUL) | (bus.mult_type == MULT_MULW);
        signed_in = (bus.mult_type == MULT_DIV) | (bus.mult_type == MULT_REM);
        rem_in    = (bus.mult_type == MULT_REM) | (bus.mult_type == MULT_REMU);
        a_ext     = bus.src_a;
        b_ext     = bus.src_b;
        if (word_in) begin
            a_ext = signed_in ? sext32(bus.src_a[31:0]) : {{(XLEN-32){1'b0}}, bus.src_a[31:0]};
            b_ext = signed_in ? sext32(bus.src_b[31:0]) : {{(XLEN-32){1'b0}}, bus.src_b[31:0]};
        end
        min_ext  = word_in ? sext32(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        sa       = signed_in & a_ext[XLEN-1];
        sb       = signed_in & b_ext[XLEN-1];
        mag_a    = sa ? -a_ext : a_ext;
        mag_b    = sb ? -b_ext : b_ext;
        div_zero = (b_ext == '0);
        ovf      = signed_in && (a_ext == min_ext) && (b_ext == '1);
        spec_raw = div_zero ? (rem_in ? a_ext : '1) : (rem_in ? '0 : min_ext);
        spec_res = word_in ? sext32(spec_raw[31:0]) : spec_raw;
    end

    logic [XLEN-1:0] acc_nx, rem_nx, quo_nx, q_mag, div_raw, fin_div, fin_mul;
    logic [XLEN:0]   rem_sh, rem_diff;
    logic            ge;

    // One iteration step for each datapath, plus the final result as seen
    // on the last iteration (sign fix-up and word sign-extension included).
    always_comb begin
        acc_nx   = acc + (mplier[0] ? mcand : '0);
        rem_sh   = {rem, quo[XLEN-1]};
        rem_diff = rem_sh - {1'b0, divisor};
        ge       = ~rem_diff[XLEN];
        rem_nx   = ge ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        quo_nx   = {quo[XLEN-2:0], ge};
        q_mag    = word_q ? {{(XLEN-32){1'b0}}, quo_nx[31:0]} : quo_nx;
        div_raw  = rem_q ? (r_neg ? -rem_nx : rem_nx) : (q_neg ? -q_mag : q_mag);
        fin_div  = word_q ? sext32(div_raw[31:0]) : div_raw;
        fin_mul  = word_q ? sext32(acc_nx[31:0]) : acc_nx;
    end

    // Sequencing FSM with registered handshake outputs and result.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            cnt          <= '0;
            word_q       <= 1'b0;
            rem_q        <= 1'b0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            rem          <= '0;
            quo          <= '0;
            divisor      <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            result_q     <= '0;
        end else if (bus.flush) begin
            state        <= S_IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        word_q      <= word_in;
                        rem_q       <= rem_in;
                        cnt         <= word_in ? CNT_WORD : CNT_FULL;
                        if (mul_in) begin
                            acc    <= '0;
                            mcand  <= a_ext;
                            mplier <= b_ext;
                            state  <= S_MUL;
                        end else if (div_zero || ovf) begin
                            result_q     <= spec_res;
                            resp_valid_q <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            // Word dividends start in the top half so quo[MSB]
                            // feeds their bits on the 32 iterations.
                            rem     <= '0;
                            quo     <= word_in ? {mag_a[31:0], {(XLEN-32){1'b0}}} : mag_a;
                            divisor <= mag_b;
                            q_neg   <= sa ^ sb;
                            r_neg   <= sa;
                            state   <= S_DIV;
                        end
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                S_MUL: begin
                    acc    <= acc_nx;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (cnt == '0) begin
                        result_q     <= fin_mul;
                        resp_valid_q <= 1'b1;
                        state        <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DIV: begin
                    rem <= rem_nx;
                    quo <= quo_nx;
                    if (cnt == '0) begin
                        result_q     <= fin_div;
                        resp_valid_q <= 1'b1;
                        state        <= S_DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.result     = result_q;

endmodule
